// File: rtl/dt1_pkg.sv
// dt1_pkg: shared encodings for the multicycle RV32I control unit.
//   - ALU control codes driven to the datapath ALU
//   - RV32I major opcodes recognised by the decoder
//   - 15-state FSM encoding (4 bits)
//   - ALU-decode class codes and datapath mux-select encodings
package dt1_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_BGE  = 4'b1010;
  localparam logic [3:0] ALU_BGEU = 4'b1011;
  localparam logic [3:0] ALU_BNE  = 4'b1100;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14
  } state_e;

  // ALU decode class: which table funct3/funct7b5 are looked up in
  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_R   = 2'd1;
  localparam logic [1:0] CLS_I   = 2'd2;
  localparam logic [1:0] CLS_BR  = 2'd3;

  // Datapath mux selects
  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_RESULT  = 1'b1;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [2:0] IMM_I       = 3'b000;
  localparam logic [2:0] IMM_S       = 3'b001;
  localparam logic [2:0] IMM_B       = 3'b010;
  localparam logic [2:0] IMM_U       = 3'b011;
  localparam logic [2:0] IMM_J       = 3'b100;

endpackage

// File: rtl/dt1_alu_dec.sv
// dt1_alu_dec: combinational ALU control decoder.
// Ports:
//   cls_i         ALU decode class from the FSM (CLS_ADD/CLS_R/CLS_I/CLS_BR)
//   funct3_i      IR[14:12]
//   funct7b5_i    IR[30]
//   alu_control_o 4-bit ALU control code
module dt1_alu_dec
  import dt1_pkg::*;
(
  input  logic [1:0] cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (cls_i)
      CLS_R, CLS_I: begin
        case (funct3_i)
          // funct7b5 selects sub only for register-register ops; for addi it is immediate bits
          3'b000:  alu_control_o = (cls_i == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
      CLS_BR: begin
        case (funct3_i)
          3'b000:  alu_control_o = ALU_SUB;
          3'b001:  alu_control_o = ALU_BNE;
          3'b100:  alu_control_o = ALU_SLT;
          3'b101:  alu_control_o = ALU_BGE;
          3'b110:  alu_control_o = ALU_SLTU;
          3'b111:  alu_control_o = ALU_BGEU;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/dt1_mc_ctrl.sv
// dt1_mc_ctrl: multicycle RV32I control FSM.
// Sequences FETCH/DECODE/execute/memory/writeback and drives datapath mux
// selects, write strobes and the ALU control code.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   op, funct3,       instruction register fields (valid from DECODE on)
//   funct7b5
//   branch_cond       ALU branch condition, qualifies pc_write in BRANCH
//   mem_ready         memory done (ignored when HAS_MEM_HANDSHAKE=0)
//   mem_req,mem_write memory request / store strobe
//   adr_src           memory address select (0=PC, 1=result)
//   ir_write,pc_write,reg_write  architectural write strobes
//   alu_src_a/b, result_src, imm_src  datapath mux selects
//   alu_control       ALU control code
//   illegal_instr     one-cycle pulse on unsupported opcode/branch funct3
module dt1_mc_ctrl
  import dt1_pkg::*;
#(
  parameter bit HAS_MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic       ready;
  logic       br_bad;
  logic       mem_req_d, mem_write_d, ir_write_d, pc_write_d, reg_write_d, illegal_d;
  logic       adr_src_d;
  logic [1:0] src_a_d, src_b_d, result_d, cls_d;
  logic [2:0] imm_d;

  assign ready  = HAS_MEM_HANDSHAKE ? mem_ready : 1'b1;
  // funct3 010/011 have no branch encoding in RV32I
  assign br_bad = (funct3[2:1] == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    adr_src_d   = ADR_PC;
    src_a_d     = SRCA_PC;
    src_b_d     = SRCB_RS2;
    result_d    = RES_ALUOUT;
    imm_d       = IMM_I;
    cls_d       = CLS_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_d  = 1'b1;
        src_b_d    = SRCB_FOUR;
        result_d   = RES_ALU;
        ir_write_d = ready;
        pc_write_d = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures old_pc + imm as a speculative branch/jal target
        src_a_d = SRCA_OLDPC;
        src_b_d = SRCB_IMM;
        imm_d   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_d = SRCA_RS1;
        src_b_d = SRCB_IMM;
        imm_d   = (op == OP_LOAD) ? IMM_I : IMM_S;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_d = 1'b1;
        adr_src_d = ADR_RESULT;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_d    = RES_MEM;
        reg_write_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        adr_src_d   = ADR_RESULT;
        if (ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        src_a_d = SRCA_RS1;
        src_b_d = SRCB_RS2;
        cls_d   = CLS_R;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a_d = SRCA_RS1;
        src_b_d = SRCB_IMM;
        imm_d   = IMM_I;
        cls_d   = CLS_I;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        result_d    = RES_ALUOUT;
        reg_write_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // Target was computed in DECODE; result_src picks it from ALUOut
        src_a_d    = SRCA_RS1;
        src_b_d    = SRCB_RS2;
        result_d   = RES_ALUOUT;
        cls_d      = CLS_BR;
        pc_write_d = branch_cond & ~br_bad;
        illegal_d  = br_bad;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        src_a_d    = SRCA_OLDPC;
        src_b_d    = SRCB_FOUR;
        result_d   = RES_ALUOUT;
        pc_write_d = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        src_a_d    = SRCA_RS1;
        src_b_d    = SRCB_IMM;
        imm_d      = IMM_I;
        result_d   = RES_ALU;
        pc_write_d = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        // rs1 may equal rd, so the link is written only after PC is updated
        src_a_d     = SRCA_OLDPC;
        src_b_d     = SRCB_FOUR;
        result_d    = RES_ALU;
        reg_write_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_LUI: begin
        src_a_d = SRCA_ZERO;
        src_b_d = SRCB_IMM;
        imm_d   = IMM_U;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a_d = SRCA_OLDPC;
        src_b_d = SRCB_IMM;
        imm_d   = IMM_U;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  dt1_alu_dec u_alu_dec (
    .cls_i        (cls_d),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .alu_control_o(alu_control)
  );

  // Reset holds the state in FETCH, so selects already show FETCH values;
  // only the strobes need masking while reset is high.
  assign mem_req       = mem_req_d   & ~reset;
  assign mem_write     = mem_write_d & ~reset;
  assign ir_write      = ir_write_d  & ~reset;
  assign pc_write      = pc_write_d  & ~reset;
  assign reg_write     = reg_write_d & ~reset;
  assign illegal_instr = illegal_d   & ~reset;
  assign adr_src       = adr_src_d;
  assign alu_src_a     = src_a_d;
  assign alu_src_b     = src_b_d;
  assign result_src    = result_d;
  assign imm_src       = imm_d;

endmodule

// File: doc/dt1_mc_ctrl.md
Name: dt1_mc_ctrl

Overview:
Multicycle RV32I control FSM. It decodes the instruction register fields, sequences fetch/decode/execute/memory/writeback, and drives the ALU's 4-bit control code. It consumes the ALU's BranchCond to decide whether a branch is taken. It sits between the instruction register and the datapath muxes, and handshakes with a unified instruction/data memory.

Parameters:
HAS_MEM_HANDSHAKE, 1, when 0 mem_ready is ignored and treated as 1.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high.
op  in  7  IR[6:0]; valid from DECODE onward.
funct3  in  3  IR[14:12].
funct7b5  in  1  IR[30].
branch_cond  in  1  ALU BranchCond.
mem_ready  in  1  memory done; read data valid / write accepted.
mem_req  out  1  memory access request.
mem_write  out  1  store strobe, qualified by mem_req.
adr_src  out  1  address select: 0=PC, 1=result.
ir_write  out  1  load IR and old_pc.
pc_write  out  1  load PC from result.
reg_write  out  1  register file write.
alu_src_a  out  2  ALU A select: 00=PC, 01=old_pc, 10=rs1 reg, 11=zero.
alu_src_b  out  2  ALU B select: 00=rs2 reg, 01=imm, 10=const 4.
result_src  out  2  result select: 00=ALUOut reg, 01=mem data reg, 10=ALU y direct.
imm_src  out  3  immediate format: 000=I, 001=S, 010=B, 011=U, 100=J.
alu_control  out  4  ALU control code.
illegal_instr  out  1  one-cycle pulse on an unsupported opcode or funct3.

Behaviour:
- ALU codes: add 0000, sub 0001, and 0010, or 0011, sll 0100, slt 0101, sltu 0110, xor 0111, sra 1000, srl 1001, bge 1010, bgeu 1011, bne 1100.
- Outputs are a Moore decode of the state. Exceptions are pc_write in BRANCH and the mem_ready-qualified strobes.
- Reset: state goes to FETCH immediately, mid-instruction included. While reset is high, mem_req, mem_write, ir_write, pc_write, reg_write and illegal_instr are forced to 0. Mux selects take their FETCH values.
- Default in every state: all strobes 0, alu_control=0000.
- FETCH:
  - mem_req=1, adr_src=0, A=00, B=10, add, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Hold in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - A=01, B=01, add; ALUOut captures the target.
  - imm_src=100 when op=1101111, else 010.
- DECODE next state by opcode:
  - load 0000011 or store 0100011 -> MEMADR.
  - R-type 0110011 -> EXEC_R.
  - I-type 0010011 -> EXEC_I.
  - branch 1100011 -> BRANCH.
  - jal 1101111 -> JAL.
  - jalr 1100111 -> JALR.
  - lui 0110111 -> LUI.
  - auipc 0010111 -> AUIPC.
  - any other opcode: illegal_instr=1 for one cycle, then FETCH.
- MEMADR: A=10, B=01, add; imm_src=000 for load, 001 for store. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready, then FETCH.
- EXEC_R: A=10, B=00. Code by funct3:
  - 000: add, or sub when funct7b5=1.
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - 101: srl, or sra when funct7b5=1.
  - Next is ALUWB.
- EXEC_I: A=10, B=01, imm 000. Same decode as EXEC_R except funct3=000 is always add (funct7b5 ignored). Next is ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: A=10, B=00, result_src=00, pc_write=branch_cond, then FETCH. Code by funct3:
  - 000 -> 0001 (beq, taken when zero).
  - 001 -> 1100 (bne).
  - 100 -> 0101 (blt).
  - 101 -> 1010 (bge).
  - 110 -> 0110 (bltu).
  - 111 -> 1011 (bgeu).
  - 010 or 011: pc_write=0 and illegal_instr=1.
- JAL: A=01, B=10, add, result_src=00, pc_write=1, then ALUWB (writes old_pc+4).
- JALR: A=10, B=01, imm 000, add, result_src=10, pc_write=1, then JALR_LINK. Clearing bit 0 of the target is done in the datapath.
- JALR_LINK: A=01, B=10, add, result_src=10, reg_write=1, then FETCH.
- LUI: A=11, B=01, imm 011, add, then ALUWB.
- AUIPC: A=01, B=01, imm 011, add, then ALUWB.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Cycle counts: R/I/AUIPC/LUI/JAL 4, load 5, store 4, branch 3, JALR 4. This assumes zero wait states; each wait cycle adds 1.

Decomposition:
- dt1_pkg holds:
  - ALU code localparams;
  - opcode localparams;
  - state encoding (15 states, 4-bit);
  - mux-select encodings.
- Sub-module dt1_alu_dec: combinational (state class, funct3, funct7b5) -> alu_control. It is instantiated once.

Test Plan:
- Reset asserted mid-MEMREAD (mem_ready=0) -> all strobes 0 the same cycle; first edge after deassert sees FETCH with mem_req=1.
- add (op=0110011, f3=000, f7b5=0), mem_ready=1 -> alu_control 0000 in EXEC_R; reg_write=1 in cycle 4; back to FETCH in cycle 5. Same with f7b5=1 -> 0001.
- beq with branch_cond=1, then bge (f3=101) with branch_cond=0 -> alu_control 0001 with pc_write=1; then 1010 with pc_write=0; BRANCH is the 3rd cycle.
- Load with mem_ready low 3 cycles in MEMREAD -> mem_req and adr_src=1 held 4 cycles; MEMWB reg_write=1 exactly once; addi f3=000 f7b5=1 -> 0000.
- jalr -> pc_write=1, result_src=10 in JALR; next cycle reg_write=1, A=01, B=10.
- op=1111111, and separately branch f3=010 -> illegal_instr pulses exactly 1 cycle with no pc_write/reg_write; FETCH follows.
